bcd5311_seq_ctrl: RTL
=====================

BCD5311_SEQ_CTRL -- requirements
Module: bcd5311_seq_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of BCD digits per word.
REQ-002 SHALL have parameter BW, default 14: binary result width; BW SHALL be >= ceil(log2(10^NDIG)).
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a word.
REQ-007 SHALL have port in_data, input, 4*NDIG bits: packed BCD 5311 digits, MSD in [4*NDIG-1 -: 4].
REQ-008 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out_data, output, 4*NDIG bits: packed BCD 8421 digits, same digit order as in_data.
REQ-011 SHALL have port out_bin, output, BW bits: binary value of the word.
REQ-012 SHALL have port out_err, output, 1 bit: at least one input digit was not a legal 5311 code.
REQ-013 SHALL have port out_err_idx, output, clog2(NDIG) bits: digit index of the highest-index illegal digit.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, DONE.
REQ-015 SHALL assert in_ready only in IDLE; in_ready SHALL be a registered state decode, not depend on in_valid.
REQ-016 SHALL transition IDLE->CONV on in_valid&&in_ready, latch in_data, clear out_bin/out_err/out_err_idx, set digit index to NDIG-1.
REQ-017 In CONV, SHALL convert exactly one digit per cycle, MSD first, decrementing the index; after index 0 it SHALL enter DONE.
REQ-018 SHALL use the legal 5311->8421 map 0000->0, 0001->1, 0011->2, 0100->3, 0101->4, 0111->5, 1001->6, 1011->7, 1100->8, 1101->9.
REQ-019 For each legal digit d: out_data slice = d; out_bin = out_bin*10 + d, truncated to BW bits.
REQ-020 For an illegal digit: out_data slice = 4'hF; out_bin = out_bin*10 (contributes 0); out_err set (sticky for the word); out_err_idx = index, only on the first illegal digit.
REQ-021 In DONE, SHALL hold out_valid=1 and all outputs stable until out_ready=1; on out_valid&&out_ready it SHALL go to IDLE.
REQ-022 Latency: an accept at cycle T SHALL give out_valid=1 from cycle T+NDIG+1; throughput is one word per NDIG+2 cycles at best.
REQ-023 in_valid SHALL be ignored outside IDLE; in_data changes after acceptance SHALL NOT affect the result.
REQ-024 out_data, out_bin, out_err and out_err_idx SHALL be don't-care when out_valid=0, but SHALL be driven only from registers.

Reset
REQ-025 rst=1 at any clock edge SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, out_data=0, out_bin=0, out_err=0, out_err_idx=0, index=NDIG-1.
REQ-026 Reset during CONV or DONE SHALL discard the in-flight word with no output handshake.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the ten legal 5311 code constants.
REQ-028 Digit conversion SHALL be one combinational sub-module, bcd5311_digit_dec (4-bit in; 4-bit value out; 1-bit legal out), instantiated once and time-shared.

Verification
REQ-029 Accept in_data=16'h1345 -> after 5 cycles: out_data=16'h1234, out_bin=1234, out_err=0.
REQ-030 Accept in_data=16'hDDDD -> out_data=16'h9999, out_bin=9999, out_err=0.
REQ-031 Accept in_data=16'h12DD -> out_data=16'h1F99, out_bin=1099, out_err=1, out_err_idx=2.
REQ-032 Accept 16'h1345 with out_ready=0 for 10 cycles -> out_valid and outputs held constant; in_ready=0 throughout; release -> IDLE next cycle.
REQ-033 Pulse rst in the 2nd CONV cycle -> next cycle IDLE, in_ready=1, out_valid=0; a new word 16'h0000 then yields out_data=0, out_bin=0.
REQ-034 Hold in_valid=1 continuously with alternating words 16'h1345/16'hDDDD, out_ready=1 -> each result appears once, in order, spaced NDIG+2 cycles.

Source files
------------

// File: rtl/bcd5311_pkg.sv
// Shared types and constants for the BCD 5311 -> 8421 sequential converter.
package bcd5311_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal 5311 codes, indexed by the decimal value they represent
  localparam logic [3:0] C5311_0 = 4'b0000;
  localparam logic [3:0] C5311_1 = 4'b0001;
  localparam logic [3:0] C5311_2 = 4'b0011;
  localparam logic [3:0] C5311_3 = 4'b0100;
  localparam logic [3:0] C5311_4 = 4'b0101;
  localparam logic [3:0] C5311_5 = 4'b0111;
  localparam logic [3:0] C5311_6 = 4'b1001;
  localparam logic [3:0] C5311_7 = 4'b1011;
  localparam logic [3:0] C5311_8 = 4'b1100;
  localparam logic [3:0] C5311_9 = 4'b1101;

  // Marker written into the output slice of an illegal input digit
  localparam logic [3:0] BAD_DIGIT = 4'hF;

endpackage

// File: rtl/bcd5311_digit_dec.sv
// Combinational single-digit 5311 -> 8421 decoder with legality flag.
module bcd5311_digit_dec
  import bcd5311_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] value,
  output logic       legal
);

  // Map the ten legal codes; anything else is flagged illegal with value 0
  always_comb begin
    value = 4'd0;
    legal = 1'b1;
    case (code)
      C5311_0: value = 4'd0;
      C5311_1: value = 4'd1;
      C5311_2: value = 4'd2;
      C5311_3: value = 4'd3;
      C5311_4: value = 4'd4;
      C5311_5: value = 4'd5;
      C5311_6: value = 4'd6;
      C5311_7: value = 4'd7;
      C5311_8: value = 4'd8;
      C5311_9: value = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/bcd5311_seq_ctrl.sv
// Sequential BCD 5311 word converter: one digit per cycle, MSD first,
// producing packed 8421 digits, the binary value and an illegal-digit flag.
module bcd5311_seq_ctrl
  import bcd5311_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int BW   = 14,
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic [BW-1:0]     out_bin,
  output logic              out_err,
  output logic [IW-1:0]     out_err_idx
);

  localparam int unsigned DW = 4 * NDIG;

  state_e          state_q;
  logic [DW-1:0]   word_q;
  logic [IW-1:0]   idx_q;
  logic [3:0]      cur_code;
  logic [3:0]      dig_val;
  logic            dig_legal;
  logic [BW-1:0]   bin_next;

  // Select the digit currently being converted from the latched word
  assign cur_code = word_q[{idx_q, 2'b00} +: 4];

  bcd5311_digit_dec u_dec (
    .code  (cur_code),
    .value (dig_val),
    .legal (dig_legal)
  );

  // Running binary accumulation; illegal digits contribute zero
  assign bin_next = BW'(out_bin * BW'(10)) + (dig_legal ? BW'(dig_val) : BW'(0));

  // Controller FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_bin     <= '0;
      out_err     <= 1'b0;
      out_err_idx <= '0;
      idx_q       <= IW'(NDIG - 1);
      word_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            state_q     <= ST_CONV;
            in_ready    <= 1'b0;
            word_q      <= in_data;
            out_bin     <= '0;
            out_err     <= 1'b0;
            out_err_idx <= '0;
            idx_q       <= IW'(NDIG - 1);
          end
        end
        ST_CONV: begin
          out_data[{idx_q, 2'b00} +: 4] <= dig_legal ? dig_val : BAD_DIGIT;
          out_bin <= bin_next;
          // First illegal digit seen is the highest-index one (MSD first)
          if (!dig_legal && !out_err) begin
            out_err     <= 1'b1;
            out_err_idx <= idx_q;
          end
          if (idx_q == '0) begin
            state_q   <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
